// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the PC, fetches over a req/ready memory handshake and
// presents one buffered instruction (or a NOP bubble) to IF/ID. Define IF_FETCH_STATS_EN for fetch/bubble counters.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        stall,
    input  logic        stallstall,
    input  logic        Redirect,
    input  logic [31:0] Redirect_PC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] IF_PCadd4,
    output logic [31:0] IF_Inst,
    output logic        IF_Valid
`ifdef IF_FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] bubble_count
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] buf_inst;
    logic [31:0] buf_pc;
    logic [31:0] drop_target;
    logic        en;
    logic [31:0] redirect_target;

    assign en              = ~stall & ~stallstall;
    assign redirect_target = Redirect_PC & ~32'h0000_0003;

    // In S_DROP pc keeps the squashed address so imem_addr stays stable until the memory answers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            buf_inst    <= NOP_INST;
            buf_pc      <= RESET_PC;
            drop_target <= RESET_PC;
        end else begin
            case (state)
                S_REQ: begin
                    if (Redirect) begin
                        if (imem_ready) begin
                            pc <= redirect_target;
                        end else begin
                            drop_target <= redirect_target;
                            state       <= S_DROP;
                        end
                    end else if (imem_ready) begin
                        buf_inst <= imem_rdata;
                        buf_pc   <= pc;
                        state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (Redirect) begin
                        pc    <= redirect_target;
                        state <= S_REQ;
                    end else if (en) begin
                        pc    <= buf_pc + 32'd4;
                        state <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_ready) begin
                        pc    <= Redirect ? redirect_target : drop_target;
                        state <= S_REQ;
                    end else if (Redirect) begin
                        drop_target <= redirect_target;
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

    // Outputs depend only on state and Reset, never on memory data, stalls or redirects.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc;
        IF_Valid  = 1'b0;
        IF_Inst   = NOP_INST;
        IF_PCadd4 = pc + 32'd4;
        if (Reset) begin
            IF_PCadd4 = RESET_PC + 32'd4;
        end else begin
            case (state)
                S_REQ: begin
                    imem_req = 1'b1;
                end
                S_HOLD: begin
                    IF_Valid  = 1'b1;
                    IF_Inst   = buf_inst;
                    IF_PCadd4 = buf_pc + 32'd4;
                end
                S_DROP: begin
                    imem_req = 1'b1;
                end
                default: begin
                    imem_req = 1'b0;
                end
            endcase
        end
    end

`ifdef IF_FETCH_STATS_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fetch_count  <= 32'd0;
            bubble_count <= 32'd0;
        end else if (en) begin
            if (IF_Valid) begin
                fetch_count <= fetch_count + 32'd1;
            end else begin
                bubble_count <= bubble_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed scenarios push expected IF/ID transfers and
// completed memory addresses; independent monitors pop and compare them.
module tb_if_fetch_unit;

    logic        Clk;
    logic        Reset;
    logic        stall;
    logic        stallstall;
    logic        Redirect;
    logic [31:0] Redirect_PC;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] IF_PCadd4;
    logic [31:0] IF_Inst;
    logic        IF_Valid;

    int total = 0;
    int bad = 0;
    int mem_wait = 0;

    logic [63:0] xfer_q[$];
    logic [31:0] addr_q[$];

    if_fetch_unit dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .stall       (stall),
        .stallstall  (stallstall),
        .Redirect    (Redirect),
        .Redirect_PC (Redirect_PC),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_ready  (imem_ready),
        .IF_PCadd4   (IF_PCadd4),
        .IF_Inst     (IF_Inst),
        .IF_Valid    (IF_Valid)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0013;
    endfunction

    task automatic check_output(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_fetch(input logic [31:0] a);
        xfer_q.push_back({a + 32'd4, inst_of(a)});
    endtask

    task automatic wait_hold(input string name, input logic [31:0] pcadd4);
        bit found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (IF_Valid === 1'b1 && IF_PCadd4 === pcadd4) found = 1'b1;
            else step();
        end
        total++;
        if (!found) begin
            bad++;
            $display("[TB] FAIL %s: timeout waiting for IF_PCadd4=%h, got %h", name, pcadd4, IF_PCadd4);
        end
    endtask

    task automatic wait_req(input string name, input logic [31:0] a);
        bit found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (imem_req === 1'b1 && imem_addr === a) found = 1'b1;
            else step();
        end
        total++;
        if (!found) begin
            bad++;
            $display("[TB] FAIL %s: timeout waiting for imem_addr=%h, got %h", name, a, imem_addr);
        end
    endtask

    // Instruction memory: answers after mem_wait wait cycles, returns inst_of(address).
    initial begin
        int wait_cnt;
        wait_cnt   = 0;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(negedge Clk);
            if (Reset !== 1'b0 || imem_req !== 1'b1) begin
                wait_cnt   = 0;
                imem_ready = 1'b0;
            end else begin
                if (imem_ready) wait_cnt = 0;
                if (wait_cnt >= mem_wait) begin
                    imem_ready = 1'b1;
                    imem_rdata = inst_of(imem_addr);
                end else begin
                    imem_ready = 1'b0;
                    wait_cnt++;
                end
            end
        end
    end

    // Monitor: IF/ID transfers, completed memory requests and handshake stability.
    initial begin
        logic [63:0] exp_x;
        logic [31:0] exp_a;
        logic        pend;
        logic [31:0] pend_addr;
        pend      = 1'b0;
        pend_addr = 32'h0;
        forever begin
            @(negedge Clk);
            #1;
            if (Reset === 1'b0) begin
                if (IF_Valid === 1'b1 && !stall && !stallstall) begin
                    if (xfer_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL xfer_unexpected: got pcadd4=%h inst=%h, want none", IF_PCadd4, IF_Inst);
                    end else begin
                        exp_x = xfer_q.pop_front();
                        check_output("xfer", {8'h0, IF_PCadd4, IF_Inst}, {8'h0, exp_x});
                    end
                end
                if (imem_req === 1'b1 && imem_ready === 1'b1) begin
                    if (addr_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL req_unexpected: got addr=%h, want none", imem_addr);
                    end else begin
                        exp_a = addr_q.pop_front();
                        check_output("req_addr", {40'h0, imem_addr}, {40'h0, exp_a});
                    end
                end
                if (pend) check_output("handshake_stable", {39'h0, imem_req, imem_addr}, {39'h0, 1'b1, pend_addr});
                pend      = (imem_req === 1'b1) && (imem_ready !== 1'b1);
                pend_addr = imem_addr;
            end else begin
                pend = 1'b0;
            end
        end
    end

    task automatic apply_stimulus();
        Reset = 1'b1; stall = 1'b0; stallstall = 1'b0;
        Redirect = 1'b0; Redirect_PC = 32'h0; mem_wait = 0;
        step();
        step();
        check_output("reset_out", {38'h0, imem_req, IF_Valid, IF_Inst, IF_PCadd4}, {38'h0, 1'b0, 1'b0, 32'h0, 32'h4});

        // Zero-wait sequential fetch; IF_Valid alternates bubble/instruction.
        addr_q.push_back(32'h0); addr_q.push_back(32'h4);
        addr_q.push_back(32'h8); addr_q.push_back(32'hC);
        push_fetch(32'h0); push_fetch(32'h4); push_fetch(32'h8); push_fetch(32'hC);
        Reset = 1'b0;
        #1;
        for (int i = 0; i < 6; i++) begin
            check_output("valid_alternate", {71'h0, IF_Valid}, {71'h0, (i % 2) == 1});
            if (i < 5) step();
        end
        wait_hold("hold_0c", 32'h10);
        mem_wait = 3;

        // Three wait cycles at 0x10.
        addr_q.push_back(32'h10);
        push_fetch(32'h10);
        for (int i = 0; i < 3; i++) begin
            step();
            check_output("wait_addr_10", {38'h0, imem_req, IF_Valid, imem_addr, 32'h0}, {38'h0, 1'b1, 1'b0, 32'h10, 32'h0});
        end
        wait_hold("hold_10", 32'h14);
        stall = 1'b1;
        mem_wait = 0;

        // Held instruction survives stall then stallstall.
        for (int i = 0; i < 6; i++) begin
            if (i == 4) begin
                stallstall = 1'b1;
                stall = 1'b0;
            end
            step();
            check_output("hold_stalled", {6'h0, IF_Valid, imem_req, IF_PCadd4, IF_Inst}, {6'h0, 1'b1, 1'b0, 32'h14, inst_of(32'h10)});
        end
        stallstall = 1'b0;
        addr_q.push_back(32'h14);
        step();
        check_output("next_after_stall", {39'h0, imem_req, imem_addr}, {39'h0, 1'b1, 32'h14});

        // Redirect while 0x20 waits: squashed request completes, 0x20 data never presented.
        addr_q.push_back(32'h18); addr_q.push_back(32'h1C);
        addr_q.push_back(32'h20); addr_q.push_back(32'h400);
        push_fetch(32'h14); push_fetch(32'h18); push_fetch(32'h1C);
        wait_hold("hold_1c", 32'h20);
        mem_wait = 2;
        step();
        check_output("req_20", {39'h0, imem_req, imem_addr}, {39'h0, 1'b1, 32'h20});
        Redirect = 1'b1;
        Redirect_PC = 32'h0000_0401;
        step();
        Redirect = 1'b0;
        check_output("drop_addr_a", {38'h0, imem_req, IF_Valid, imem_addr, 32'h0}, {38'h0, 1'b1, 1'b0, 32'h20, 32'h0});
        step();
        check_output("drop_addr_b", {38'h0, imem_req, IF_Valid, imem_addr, 32'h0}, {38'h0, 1'b1, 1'b0, 32'h20, 32'h0});
        wait_req("req_400", 32'h400);
        mem_wait = 0;
        stall = 1'b1;
        step();
        check_output("hold_400", {7'h0, IF_Valid, IF_PCadd4, IF_Inst}, {7'h0, 1'b1, 32'h404, inst_of(32'h400)});

        // Redirect in S_HOLD with En=0 discards, with En=1 transfers once.
        addr_q.push_back(32'h80);
        Redirect = 1'b1;
        Redirect_PC = 32'h80;
        step();
        Redirect = 1'b0;
        stall = 1'b0;
        check_output("redirect_hold_en0", {38'h0, imem_req, IF_Valid, imem_addr, 32'h0}, {38'h0, 1'b1, 1'b0, 32'h80, 32'h0});
        push_fetch(32'h80);
        addr_q.push_back(32'h80);
        wait_hold("hold_80", 32'h84);
        Redirect = 1'b1;
        Redirect_PC = 32'h80;
        step();
        Redirect = 1'b0;
        stall = 1'b1;
        check_output("redirect_hold_en1", {38'h0, imem_req, IF_Valid, imem_addr, 32'h0}, {38'h0, 1'b1, 1'b0, 32'h80, 32'h0});
        wait_hold("hold_80_again", 32'h84);

        // Reset in S_HOLD and mid-wait, then PC wrap.
        Reset = 1'b1;
        #1;
        check_output("reset_during", {38'h0, imem_req, IF_Valid, IF_Inst, IF_PCadd4}, {38'h0, 1'b0, 1'b0, 32'h0, 32'h4});
        step();
        check_output("reset_from_hold", {38'h0, imem_req, IF_Valid, IF_Inst, IF_PCadd4}, {38'h0, 1'b0, 1'b0, 32'h0, 32'h4});
        Reset = 1'b0;
        stall = 1'b0;
        mem_wait = 3;
        #1;
        check_output("req_after_reset", {39'h0, imem_req, imem_addr}, {39'h0, 1'b1, 32'h0});
        step();
        check_output("midwait_addr", {39'h0, imem_req, imem_addr}, {39'h0, 1'b1, 32'h0});
        Reset = 1'b1;
        step();
        check_output("reset_midwait", {38'h0, imem_req, IF_Valid, IF_Inst, IF_PCadd4}, {38'h0, 1'b0, 1'b0, 32'h0, 32'h4});
        Reset = 1'b0;
        mem_wait = 0;
        addr_q.push_back(32'h0); addr_q.push_back(32'hFFFF_FFFC); addr_q.push_back(32'h0);
        Redirect = 1'b1;
        Redirect_PC = 32'hFFFF_FFFC;
        step();
        Redirect = 1'b0;
        check_output("redirect_ready", {38'h0, imem_req, IF_Valid, imem_addr, 32'h0}, {38'h0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0});
        push_fetch(32'hFFFF_FFFC);
        wait_hold("hold_wrap", 32'h0);
        check_output("wrap_inst", {39'h0, IF_Valid, IF_Inst}, {39'h0, 1'b1, inst_of(32'hFFFF_FFFC)});
        step();
        check_output("wrap_addr", {39'h0, imem_req, imem_addr}, {39'h0, 1'b1, 32'h0});
        wait_hold("hold_after_wrap", 32'h4);
        stall = 1'b1;
        check_output("hold_after_wrap_inst", {39'h0, IF_Valid, IF_Inst}, {39'h0, 1'b1, inst_of(32'h0)});
        step();
        step();
        step();
    endtask

    initial begin
        apply_stimulus();
        check_output("xfer_q_empty", 72'(xfer_q.size()), 72'h0);
        check_output("addr_q_empty", 72'(addr_q.size()), 72'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
